// File: rtl/mult2add_rr_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler in front of one shared scale(x*0.6875)-and-combine datapath, one result slot.
// Optional grant counter: define MULT2ADD_SCHED_CNT_EN to add the grant_cnt port.

module mult2add_dp #(
  parameter int DW = 20
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          s1,
  input  logic          s2,
  input  logic          sub,
  output logic [DW-1:0] y
);
  function automatic logic [DW-1:0] sc(input logic [DW-1:0] x);
    logic signed [DW-1:0] xs;
    xs = signed'(x);
    return (xs >>> 1) + (xs >>> 3) + (xs >>> 4);
  endfunction

  logic [DW-1:0] sa, sb;
  assign sa = s1 ? ~sc(a) : sc(a);
  assign sb = s2 ? ~sc(b) : sc(b);
  assign y  = sub ? sa + ~sb : sa + sb;
endmodule

module mult2add_rr_sched #(
  parameter int DATA_WIDTH = 20,
  parameter int FRAC       = 16,
  parameter int NREQ       = 4,
  parameter int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*DATA_WIDTH-1:0] req_a,
  input  logic [NREQ*DATA_WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]            req_s1,
  input  logic [NREQ-1:0]            req_s2,
  input  logic [NREQ-1:0]            req_sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [IDW-1:0]             out_id
`ifdef MULT2ADD_SCHED_CNT_EN
  ,
  output logic [31:0]                grant_cnt
`endif
);
  localparam int DW = DATA_WIDTH;

  if (NREQ < 2 || NREQ > 8 || FRAC >= DATA_WIDTH) begin : g_bad_cfg
    $error("mult2add_rr_sched: unsupported NREQ/FRAC");
  end

  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;

  logic [NREQ-1:0][DW-1:0] a_v, b_v;
  logic [IDW-1:0]          ptr, gidx;
  logic                    any, can_grant;
  logic [DW-1:0]           dp_y;

  assign a_v = req_a;
  assign b_v = req_b;
  assign can_grant = !rst && (state == EMPTY || out_ready);

  // Search starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    req_ready = '0;
    gidx      = '0;
    any       = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && can_grant && req_valid[(int'(ptr) + k) % NREQ]) begin
        any  = 1'b1;
        gidx = IDW'((int'(ptr) + k) % NREQ);
      end
    end
    if (any) req_ready[gidx] = 1'b1;
  end

  mult2add_dp #(.DW(DW)) u_dp (
    .a   (a_v[gidx]),
    .b   (b_v[gidx]),
    .s1  (req_s1[gidx]),
    .s2  (req_s2[gidx]),
    .sub (req_sub[gidx]),
    .y   (dp_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= IDW'(NREQ - 1);
    end else if (any) begin
      state     <= FULL;
      out_valid <= 1'b1;
      out_data  <= dp_y;
      out_id    <= gidx;
      ptr       <= gidx;
    end else if (out_ready) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
    end
  end

`ifdef MULT2ADD_SCHED_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)      grant_cnt <= '0;
    else if (any) grant_cnt <= grant_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_mult2add_rr_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for mult2add_rr_sched: directed vectors, then a constrained random phase.
module tb_mult2add_rr_sched;
  localparam int DW = 20, NREQ = 4, IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0, req_ready, req_s1 = '0, req_s2 = '0, req_sub = '0;
  logic [NREQ*DW-1:0]   req_a = '0, req_b = '0;
  logic                 out_valid, out_ready = 1'b1;
  logic [DW-1:0]        out_data;
  logic [IDW-1:0]       out_id;
`ifdef MULT2ADD_SCHED_CNT_EN
  logic [31:0]          grant_cnt;
`endif

  always #5 clk = ~clk;

  mult2add_rr_sched #(.DATA_WIDTH(DW), .FRAC(16), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s1(req_s1), .req_s2(req_s2), .req_sub(req_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
`ifdef MULT2ADD_SCHED_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  typedef struct { logic [IDW-1:0] id; logic [DW-1:0] data; } exp_t;
  exp_t q[$];
  int total = 0, passed = 0;
  logic started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // floor(v / 2^n) written as integer division, independent of shift semantics
  function automatic int fl(input int v, input int n);
    int d;
    d = 1 << n;
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  function automatic int unsigned scm(input logic [DW-1:0] x);
    int v;
    v = int'(x);
    if (v >= (1 << (DW-1))) v -= (1 << DW);
    return int'(fl(v, 1) + fl(v, 3) + fl(v, 4)) & ((1 << DW) - 1);
  endfunction

  function automatic int unsigned model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic s1, input logic s2, input logic sub);
    int unsigned m, sa, sb;
    m  = (1 << DW) - 1;
    sa = s1 ? m - scm(a) : scm(a);
    sb = s2 ? m - scm(b) : scm(b);
    return (sub ? sa + (m - sb) : sa + sb) & m;
  endfunction

  task automatic setreq(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic s1, input logic s2, input logic sub, input logic v);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_s1[i] = s1; req_s2[i] = s2; req_sub[i] = sub; req_valid[i] = v;
  endtask

  // Reference arbiter/slot model: predicts grants, pushes expected results
  logic            mfull = 1'b0;
  logic [IDW-1:0]  mptr  = IDW'(NREQ - 1);
  int unsigned     mcnt  = 0;
  logic [NREQ-1:0] eg, last_acc = '0;
  int              g;
  int              waitc[NREQ];
  initial forever begin
    @(negedge clk); #1;
    eg = '0; g = -1;
    if (!rst && (!mfull || out_ready))
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && req_valid[(int'(mptr) + k) % NREQ]) g = (int'(mptr) + k) % NREQ;
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", req_ready, eg);
    chk("onehot0", $onehot0(req_ready), 1);
    last_acc = req_valid & req_ready;
    if (req_ready != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          chk("no_starve", waitc[i] < NREQ, 1);
          waitc[i] = 0;
        end else if (req_valid[i]) waitc[i]++;
        else waitc[i] = 0;
      end
    end
    if (rst) begin
      mfull = 1'b0; mptr = IDW'(NREQ - 1); mcnt = 0; q.delete();
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    end else if (g >= 0) begin
      q.push_back('{id: IDW'(g), data: DW'(model(req_a[g*DW +: DW], req_b[g*DW +: DW],
                                               req_s1[g], req_s2[g], req_sub[g]))});
      mfull = 1'b1; mptr = IDW'(g); mcnt++;
    end else if (mfull && out_ready) mfull = 1'b0;
  end

  // Monitor: compares the slot against the head of the scoreboard every cycle
  initial begin
    wait (started);
    forever begin
      @(negedge clk);
      chk("out_valid", out_valid, mfull);
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_out: got id %0d data %0h expected no output", out_id, out_data);
        end else begin
          chk("out_data", out_data, q[0].data);
          chk("out_id", out_id, q[0].id);
          if (out_ready && !rst) void'(q.pop_front());
        end
      end
    end
  end

  task automatic single(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s1,
                        input logic s2, input logic sub, input logic [DW-1:0] exp);
    @(posedge clk); #1;
    setreq(0, a, b, s1, s2, sub, 1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("lat1_valid", out_valid, 1);
    chk("vec_data", out_data, exp);
    chk("vec_id", out_id, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; started = 1'b1;
    @(negedge clk);
    chk("rst_data", out_data, 0);
    chk("rst_id", out_id, 0);

    single(20'h10000, 20'h10000, 1'b0, 1'b0, 1'b0, 20'h16000);
    single(20'h10000, 20'h10000, 1'b0, 1'b0, 1'b1, 20'hFFFFF);
    single(20'hF0000, 20'h00000, 1'b0, 1'b0, 1'b0, 20'hF5000);
    single(20'h10000, 20'h00000, 1'b1, 1'b0, 1'b0, 20'hF4FFF);
    single(20'h7FFFF, 20'h7FFFF, 1'b0, 1'b0, 1'b0, 20'hAFFFA);
    single(20'h10000, 20'hF0000, 1'b0, 1'b1, 1'b1, 20'h00000);

    // all four requesters continuously valid
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) setreq(i, DW'(20'h01000 * (i + 1)), DW'(20'h00100 * i), 1'b0, 1'b0, i[0], 1'b1);
    repeat (8) @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);

    // back-pressure with req1 and req2 pending
    #1 out_ready = 1'b0;
    setreq(1, 20'h20000, 20'h08000, 1'b0, 1'b0, 1'b0, 1'b1);
    setreq(2, 20'hE0000, 20'h04000, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1 req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);

    // reset while full with requests pending
    #1 out_ready = 1'b0; req_valid = '1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
`ifdef MULT2ADD_SCHED_CNT_EN
    chk("rst_grant_cnt", grant_cnt, 0);
`endif
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_first", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk);

    // random valid/ready traffic, operands held while waiting
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++)
        if (!(req_valid[i] && !last_acc[i] && $urandom_range(0, 3) != 0))
          setreq(i, DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 1)));
    end
    #1 req_valid = '0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drained", q.size(), 0);
`ifdef MULT2ADD_SCHED_CNT_EN
    chk("grant_cnt", grant_cnt, mcnt);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
